// File: rtl/mandel_param_rx.sv
// UART packet receiver for Mandelbrot render parameters: 11-byte framed set with XOR checksum,
// double-buffered so the consumer only ever sees complete, verified sets.
module mandel_param_rx #(
   parameter int TIMEOUT_CYC = 240000,
   parameter int N_BIT       = 16
) (
   input  logic             clk24M,
   input  logic             rst_n,
   input  logic [7:0]       rx_data,
   input  logic             rx_ready,
   input  logic             param_ack,
   output logic             param_valid,
   output logic [7:0]       pix_x,
   output logic [7:0]       pix_y,
   output logic [N_BIT-1:0] cxs,
   output logic [N_BIT-1:0] cys,
   output logic [N_BIT-1:0] dcx,
   output logic [N_BIT-1:0] dcy,
   output logic             rx_busy,
   output logic             err_cksum,
   output logic             err_timeout,
   output logic             err_overrun
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RECV = 1'b1;

   logic [0:0]      state;
   logic [3:0]      idx;
   logic [7:0]      cksum;
   logic [TW-1:0]   tmo_cnt;
   logic            rx_ready_q;
   logic [9:0][7:0] shadow;

   logic strobe, cks_ok, can_load, tmo_hit;

   // Coordinates arrive as 16-bit Q12 words; widen/narrow with sign kept.
   function automatic logic [N_BIT-1:0] ext(input logic [15:0] w);
      return N_BIT'(signed'(w));
   endfunction

   assign strobe   = rx_ready & ~rx_ready_q;
   assign cks_ok   = (rx_data == cksum);
   assign can_load = ~param_valid | param_ack;
   assign tmo_hit  = (state == RECV) && !strobe && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
   assign rx_busy  = (state == RECV);

   always_ff @(posedge clk24M or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= '0;
         cksum       <= '0;
         tmo_cnt     <= '0;
         rx_ready_q  <= 1'b0;
         shadow      <= '0;
         param_valid <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         cxs         <= '0;
         cys         <= '0;
         dcx         <= '0;
         dcy         <= '0;
         err_cksum   <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         rx_ready_q  <= rx_ready;
         err_cksum   <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
         // A load below on the same edge overrides this clear.
         if (param_valid && param_ack)
            param_valid <= 1'b0;

         if (strobe) begin
            tmo_cnt <= '0;
            if (idx == 4'd10) begin
               state <= IDLE;
               idx   <= '0;
               cksum <= '0;
               if (!cks_ok)
                  err_cksum <= 1'b1;
               else if (can_load) begin
                  pix_x       <= shadow[0];
                  pix_y       <= shadow[1];
                  cxs         <= ext({shadow[2], shadow[3]});
                  cys         <= ext({shadow[4], shadow[5]});
                  dcx         <= ext({shadow[6], shadow[7]});
                  dcy         <= ext({shadow[8], shadow[9]});
                  param_valid <= 1'b1;
               end else
                  err_overrun <= 1'b1;
            end else begin
               shadow[idx] <= rx_data;
               cksum       <= cksum ^ rx_data;
               idx         <= idx + 4'd1;
               state       <= RECV;
            end
         end else if (tmo_hit) begin
            state       <= IDLE;
            idx         <= '0;
            cksum       <= '0;
            tmo_cnt     <= '0;
            err_timeout <= 1'b1;
         end else if (state == RECV)
            tmo_cnt <= tmo_cnt + TW'(1);
      end
   end

endmodule

// File: doc/mandel_param_rx.md
MANDEL_PARAM_RX -- requirements
Module: mandel_param_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 240000: inter-byte timeout in clk24M cycles (10 ms at 24 MHz).
REQ-002 SHALL have parameter N_BIT, default 16: coordinate word width (Q12 signed).
REQ-003 SHALL have port clk24M, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port rx_data, input, 8: byte from the UART receiver, stable while rx_ready high.
REQ-006 SHALL have port rx_ready, input, 1: level, high while a received byte is available.
REQ-007 SHALL have port param_ack, input, 1: consumer accepts the current parameter set.
REQ-008 SHALL have port param_valid, output, 1: a complete, checksum-verified parameter set is held.
REQ-009 SHALL have ports pix_x and pix_y, output, 8 each: image size in pixels.
REQ-010 SHALL have ports cxs, cys, dcx and dcy, output, N_BIT each: start coordinates and steps.
REQ-011 SHALL have port rx_busy, output, 1: a packet is partially received.
REQ-012 SHALL have ports err_cksum, err_timeout and err_overrun, output, 1 each: single-cycle error pulses.

Function
REQ-013 SHALL register rx_ready into rx_ready_q; a byte strobe SHALL be rx_ready & ~rx_ready_q, and rx_data SHALL be captured on the clock edge where the strobe is true.
REQ-014 SHALL accept an 11-byte packet in this order: pix_x, pix_y, cxs[15:8], cxs[7:0], cys[15:8], cys[7:0], dcx[15:8], dcx[7:0], dcy[15:8], dcy[7:0], checksum.
REQ-015 SHALL compute the checksum as the XOR of bytes 0-9; packet byte 10 must equal it.
REQ-016 SHALL keep a byte index 0..10 and store bytes 0-9 in a shadow register set; the outputs SHALL NOT change while a packet is being received.
REQ-017 SHALL use two states, IDLE (index 0) and RECV (index 1..10); rx_busy SHALL be 1 in RECV.
REQ-018 On the strobe capturing byte 10, when the checksum matches and (param_valid==0 or param_ack==1), the block SHALL copy the shadow set to the outputs and set param_valid=1 on that same edge, then return to IDLE.
REQ-019 On a checksum mismatch, the block SHALL pulse err_cksum for one cycle, leave the outputs and param_valid unchanged, and return to IDLE.
REQ-020 When the checksum matches but param_valid==1 and param_ack==0, the block SHALL drop the packet, pulse err_overrun for one cycle, and return to IDLE.
REQ-021 param_valid SHALL clear on the edge where param_valid & param_ack, unless REQ-018 loads a new set on that same edge, in which case it stays 1.
REQ-022 param_ack while param_valid==0 SHALL be ignored.
REQ-023 The timeout counter SHALL clear on every strobe and on entry to IDLE, and increment each cycle in RECV.
REQ-024 When the timeout counter reaches TIMEOUT_CYC-1 in RECV with no strobe that cycle, the block SHALL go to IDLE, reset the running checksum, and pulse err_timeout for one cycle.
REQ-025 A strobe arriving on the same cycle as the timeout SHALL win: the byte is accepted and no timeout occurs.
REQ-026 The block SHALL process at most one byte per strobe; a rx_ready held high SHALL yield exactly one byte.

Reset
REQ-027 rst_n low SHALL immediately clear all of the following:
- param_valid, rx_busy, err_cksum, err_timeout, err_overrun = 0
- pix_x, pix_y, cxs, cys, dcx, dcy = 0
- byte index, running checksum, timeout counter and rx_ready_q = 0
REQ-028 Reset asserted mid-packet SHALL discard the partial packet; after release, the next strobe SHALL be treated as byte 0.

Verification
REQ-029 Send bytes C0 80 E0 00 F0 00 00 40 00 40 50 -> param_valid=1 with pix_x=192, pix_y=128, cxs=0xE000, cys=0xF000, dcx=0x0040, dcy=0x0040; hold param_ack=1 for one cycle -> param_valid=0.
REQ-030 Same packet with last byte 0x51 -> one-cycle err_cksum, param_valid stays 0, outputs stay 0.
REQ-031 Send 4 bytes, idle 240000 cycles -> err_timeout pulses once and rx_busy=0; then a full valid packet is accepted.
REQ-032 Send a valid packet, no ack, then a second valid packet -> err_overrun, outputs still hold the first set; ack on the exact cycle the second checksum byte is captured -> second set loaded, param_valid stays 1.
REQ-033 Hold rx_ready high for 50 cycles per byte -> each byte is counted exactly once.
REQ-034 Pulse rst_n low after 6 bytes, then send a full packet -> clean decode of the new packet and no error pulses.
